refill_responder: RTL

REFILL_RESPONDER -- requirements
Module: refill_responder

---
 rtl/refill_responder_pkg.sv | 20 ++
 rtl/refill_responder_if.sv | 33 +++
 rtl/refill_responder_arbiter.sv | 53 +++++
 rtl/refill_responder.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/refill_responder_pkg.sv
// Shared types and constants for the refill responder.
// Optional feature macro: REFILL_RR_ARB_EN (round-robin arbitration).
package refill_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    RBURST,
    WCAPT,
    WDONE
  } state_e;

  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  localparam int unsigned DEF_LINE_WORDS  = 4;
  localparam int unsigned DEF_MEM_LATENCY = 10;
  localparam int unsigned DEF_MEM_WORDS   = 1024;

endpackage

// File: rtl/refill_responder_if.sv
// I/D request and response bundle between the caches and the responder.
interface refill_responder_if #(
  parameter int unsigned LINE_WORDS = refill_pkg::DEF_LINE_WORDS
);
  localparam int unsigned BW = $clog2(LINE_WORDS);

  logic          ireq_valid;
  logic [31:0]   ireq_addr;
  logic          ireq_ready;
  logic          dreq_valid;
  logic [31:0]   dreq_addr;
  logic          dreq_write;
  logic [31:0]   dreq_wdata;
  logic          dreq_ready;
  logic          resp_valid;
  logic          resp_port;
  logic [BW-1:0] resp_beat;
  logic [31:0]   resp_data;
  logic          resp_last;
  logic          wr_done;

  modport slave (
    input  ireq_valid, ireq_addr, dreq_valid, dreq_addr, dreq_write, dreq_wdata,
    output ireq_ready, dreq_ready, resp_valid, resp_port, resp_beat, resp_data,
           resp_last, wr_done
  );

  modport master (
    output ireq_valid, ireq_addr, dreq_valid, dreq_addr, dreq_write, dreq_wdata,
    input  ireq_ready, dreq_ready, resp_valid, resp_port, resp_beat, resp_data,
           resp_last, wr_done
  );
endinterface

// File: rtl/refill_responder_arbiter.sv
// Grant logic between I-cache and D-cache requests.
// REFILL_RR_ARB_EN: round-robin on ties (last-granted loses), otherwise D wins.
module refill_arbiter
  import refill_pkg::*;
(
`ifdef REFILL_RR_ARB_EN
  input  logic clk,
  input  logic rst,
`endif
  input  logic en,
  input  logic i_valid,
  input  logic d_valid,
  output logic grant_i,
  output logic grant_d
);

  logic pick_d;

`ifdef REFILL_RR_ARB_EN
  logic last_q;
  logic last_d;

  // Tie goes to the port that was not granted last; otherwise whoever asks.
  always_comb begin
    pick_d  = (i_valid && d_valid) ? (last_q == PORT_I) : d_valid;
    grant_d = en && d_valid && pick_d;
    grant_i = en && i_valid && !(d_valid && pick_d);
    last_d  = last_q;
    if (grant_d) begin
      last_d = PORT_D;
    end else if (grant_i) begin
      last_d = PORT_I;
    end
  end

  // Last-granted pointer; reset value makes D win the first tie.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_q <= PORT_I;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: D-cache always beats I-cache.
  always_comb begin
    pick_d  = d_valid;
    grant_d = en && d_valid;
    grant_i = en && i_valid && !pick_d;
  end
`endif

endmodule

// File: rtl/refill_responder.sv
// Line-refill / writeback responder serving an I-cache and a D-cache from a
// single-ported backing store, one request in flight.
// Optional feature macro: REFILL_RR_ARB_EN (round-robin arbitration).
module refill_responder
  import refill_pkg::*;
#(
  parameter int unsigned LINE_WORDS  = DEF_LINE_WORDS,
  parameter int unsigned MEM_LATENCY = DEF_MEM_LATENCY,
  parameter int unsigned MEM_WORDS   = DEF_MEM_WORDS
) (
  input logic               clk,
  input logic               rst,
  refill_responder_if.slave bus
);

  localparam int unsigned BW = $clog2(LINE_WORDS);
  localparam int unsigned AW = $clog2(MEM_WORDS);
  localparam int unsigned LW = $clog2(MEM_LATENCY + 1);
  localparam logic [BW-1:0] LAST_BEAT = BW'(LINE_WORDS - 1);
  localparam logic [LW-1:0] LAST_LAT  = LW'(MEM_LATENCY - 1);
  localparam logic [AW-1:0] LINE_MASK = ~AW'(LINE_WORDS - 1);

  state_e        state_q, state_d;
  logic [LW-1:0] lat_q, lat_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          is_write_q, is_write_d;
  logic          port_q, port_d;
  logic          resp_port_q, resp_port_d;
  logic [BW-1:0] resp_beat_q, resp_beat_d;
  logic [31:0]   resp_data_q, resp_data_d;

  logic [31:0]   mem_q [MEM_WORDS];
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [31:0]   mem_wdata;

  logic          arb_en;
  logic          grant_i;
  logic          grant_d;
  logic [AW-1:0] i_line_idx;
  logic [AW-1:0] d_line_idx;
  logic          unused_addr_bits;

  assign arb_en     = (state_q == IDLE) && !rst;
  assign i_line_idx = bus.ireq_addr[AW+1:2] & LINE_MASK;
  assign d_line_idx = bus.dreq_addr[AW+1:2] & LINE_MASK;
  assign unused_addr_bits = ^{bus.ireq_addr[31:AW+2], bus.ireq_addr[1:0],
                              bus.dreq_addr[31:AW+2], bus.dreq_addr[1:0]};

  refill_arbiter u_arb (
`ifdef REFILL_RR_ARB_EN
    .clk     (clk),
    .rst     (rst),
`endif
    .en      (arb_en),
    .i_valid (bus.ireq_valid),
    .d_valid (bus.dreq_valid),
    .grant_i (grant_i),
    .grant_d (grant_d)
  );

  // Next-state, counters, store write port and response register loads.
  // Response registers are loaded one cycle ahead so each beat is a flop output.
  always_comb begin
    state_d     = state_q;
    lat_d       = lat_q;
    beat_d      = beat_q;
    idx_d       = idx_q;
    is_write_d  = is_write_q;
    port_d      = port_q;
    resp_port_d = resp_port_q;
    resp_beat_d = resp_beat_q;
    resp_data_d = resp_data_q;
    mem_we      = 1'b0;
    mem_waddr   = idx_q + AW'(beat_q);
    mem_wdata   = bus.dreq_wdata;
    unique case (state_q)
      IDLE: begin
        lat_d  = '0;
        beat_d = '0;
        if (grant_d) begin
          idx_d      = d_line_idx;
          is_write_d = bus.dreq_write;
          port_d     = PORT_D;
          lat_d      = LW'(1);
          if (bus.dreq_write) begin
            mem_we    = 1'b1;
            mem_waddr = d_line_idx;
            beat_d    = BW'(1);
            state_d   = WCAPT;
          end else begin
            state_d = WAIT;
          end
        end else if (grant_i) begin
          idx_d      = i_line_idx;
          is_write_d = 1'b0;
          port_d     = PORT_I;
          lat_d      = LW'(1);
          state_d    = WAIT;
        end
      end
      WCAPT: begin
        mem_we = 1'b1;
        lat_d  = lat_q + LW'(1);
        if (beat_q == LAST_BEAT) begin
          beat_d = '0;
          if (lat_q == LAST_LAT) begin
            lat_d   = '0;
            state_d = WDONE;
          end else begin
            state_d = WAIT;
          end
        end else begin
          beat_d = beat_q + BW'(1);
        end
      end
      WAIT: begin
        lat_d = lat_q + LW'(1);
        if (lat_q == LAST_LAT) begin
          lat_d  = '0;
          beat_d = '0;
          if (is_write_q) begin
            state_d = WDONE;
          end else begin
            state_d     = RBURST;
            resp_port_d = port_q;
            resp_beat_d = '0;
            resp_data_d = mem_q[idx_q];
          end
        end
      end
      RBURST: begin
        if (beat_q == LAST_BEAT) begin
          beat_d  = '0;
          state_d = IDLE;
        end else begin
          beat_d      = beat_q + BW'(1);
          resp_beat_d = beat_q + BW'(1);
          resp_data_d = mem_q[idx_q + AW'(beat_q + BW'(1))];
        end
      end
      WDONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and response registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      lat_q       <= '0;
      beat_q      <= '0;
      idx_q       <= '0;
      is_write_q  <= 1'b0;
      port_q      <= PORT_I;
      resp_port_q <= PORT_I;
      resp_beat_q <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      lat_q       <= lat_d;
      beat_q      <= beat_d;
      idx_q       <= idx_d;
      is_write_q  <= is_write_d;
      port_q      <= port_d;
      resp_port_q <= resp_port_d;
      resp_beat_q <= resp_beat_d;
      resp_data_q <= resp_data_d;
    end
  end

  // Backing store; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  assign bus.ireq_ready = grant_i;
  assign bus.dreq_ready = grant_d;
  assign bus.resp_valid = (state_q == RBURST);
  assign bus.resp_last  = (state_q == RBURST) && (beat_q == LAST_BEAT);
  assign bus.wr_done    = (state_q == WDONE);
  assign bus.resp_port  = resp_port_q;
  assign bus.resp_beat  = resp_beat_q;
  assign bus.resp_data  = resp_data_q;

endmodule
